// File: rtl/control_riego.sv
// Irrigation controller fed by the frame decoder: decides pump activation from
// moisture/time/plant type, with run-time, frame-loss and soak timers plus a latched fault.
module control_riego #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int RIEGO_MAX_S = 10,
  parameter int ESPERA_S    = 30,
  parameter int TRAMA_TO_S  = 3,
  parameter int HIST        = 64,
  parameter int MAX_FALLOS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        listo,
  input  logic [11:0] humedad,
  input  logic [15:0] hora,
  input  logic [3:0]  tipoPlanta,
  input  logic        MODbomba,
  output logic        activarB,
  output logic        regando,
  output logic        fallo,
  output logic        bloqueo,
  output logic [1:0]  estado
);

  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SMAX = (ESPERA_S > RIEGO_MAX_S) ? ESPERA_S : RIEGO_MAX_S;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int TW   = (TRAMA_TO_S > 0) ? $clog2(TRAMA_TO_S + 1) : 1;

  typedef enum logic [1:0] {REPOSO = 2'd0, REGANDO = 2'd1, ESPERA = 2'd2, FALLA = 2'd3} estado_t;

  estado_t        st, nxt;
  logic [PW-1:0]  presc;
  logic [SW-1:0]  seg;
  logic [TW-1:0]  trama;
  logic [1:0]     fallas, fallas_inc;
  logic [11:0]    umbral;
  logic [12:0]    parada;
  logic           hora_ok, tick, normal, anormal, cambio;

  always_comb begin
    umbral = 12'd2000;
    unique case (tipoPlanta)
      4'd0:    umbral = 12'd1200;
      4'd1:    umbral = 12'd1800;
      4'd2:    umbral = 12'd2400;
      4'd3:    umbral = 12'd3000;
      default: umbral = 12'd2000;
    endcase
  end

  // 13-bit sum so threshold + hysteresis never wraps
  assign parada     = {1'b0, umbral} + 13'(HIST);
  assign hora_ok    = (hora < 16'h1000) || (hora >= 16'h1600);
  assign tick       = (presc == PW'(CLK_HZ - 1));
  assign fallas_inc = (fallas == 2'd3) ? 2'd3 : fallas + 2'd1;
  assign cambio     = (nxt != st);

  always_comb begin
    nxt     = st;
    normal  = 1'b0;
    anormal = 1'b0;
    unique case (st)
      REPOSO:
        if (listo && MODbomba && hora_ok && (humedad < umbral)) nxt = REGANDO;
      REGANDO:
        if (!MODbomba) begin
          nxt = REPOSO;
        end else if (listo && (({1'b0, humedad} >= parada) || !hora_ok)) begin
          nxt    = ESPERA;
          normal = 1'b1;
        end else if ((seg == SW'(RIEGO_MAX_S)) || (trama == TW'(TRAMA_TO_S))) begin
          anormal = 1'b1;
          nxt     = (fallas_inc == 2'(MAX_FALLOS)) ? FALLA : ESPERA;
        end
      ESPERA:
        if (seg == SW'(ESPERA_S)) nxt = REPOSO;
      FALLA:
        nxt = FALLA;
      default:
        nxt = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= REPOSO;
      presc    <= '0;
      seg      <= '0;
      trama    <= '0;
      fallas   <= '0;
      fallo    <= 1'b0;
      activarB <= 1'b0;
      regando  <= 1'b0;
      bloqueo  <= 1'b0;
      estado   <= 2'd0;
    end else begin
      st       <= nxt;
      estado   <= nxt;
      activarB <= (nxt == REGANDO);
      regando  <= (nxt == REGANDO);
      bloqueo  <= (nxt == FALLA);

      if (normal) begin
        fallo  <= 1'b0;
        fallas <= 2'd0;
      end else if (anormal) begin
        fallo  <= 1'b1;
        fallas <= fallas_inc;
      end

      // timebase restarts on every state entry so each timed state counts from zero
      if (cambio || tick) presc <= '0;
      else                presc <= presc + PW'(1);

      if (cambio)
        seg <= '0;
      else if (tick && (st == REGANDO || st == ESPERA))
        seg <= seg + SW'(1);

      if (listo || (cambio && nxt == REGANDO))
        trama <= '0;
      else if (tick && (trama != TW'(TRAMA_TO_S)))
        trama <= trama + TW'(1);
    end
  end

endmodule

// File: tb/tb_control_riego.sv
// Directed bench for control_riego at CLK_HZ=10: thresholds, lockout, timeouts, fault latch, reset.
module tb_control_riego;

  logic        clk = 1'b0;
  logic        rst_n, listo, MODbomba;
  logic [11:0] humedad;
  logic [15:0] hora;
  logic [3:0]  tipoPlanta;
  logic        activarB, regando, fallo, bloqueo;
  logic [1:0]  estado;

  int n_chk  = 0;
  int n_fail = 0;

  control_riego #(.CLK_HZ(10)) dut (
    .clk(clk), .rst_n(rst_n), .listo(listo), .humedad(humedad), .hora(hora),
    .tipoPlanta(tipoPlanta), .MODbomba(MODbomba), .activarB(activarB),
    .regando(regando), .fallo(fallo), .bloqueo(bloqueo), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle listo pulse; returns at the negedge after the sampling edge
  task automatic send(input logic [11:0] h, input logic [15:0] hr, input logic [3:0] tp);
    @(negedge clk);
    listo = 1'b1; humedad = h; hora = hr; tipoPlanta = tp;
    @(negedge clk);
    listo = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; listo = 1'b0; MODbomba = 1'b1;
    humedad = '0; hora = 16'h0830; tipoPlanta = 4'd1;
    cycles(3);
    chk("rst_estado", estado, 0);
    chk("rst_activarB", activarB, 0);
    chk("rst_regando", regando, 0);
    chk("rst_fallo", fallo, 0);
    chk("rst_bloqueo", bloqueo, 0);
    rst_n = 1'b1;
    cycles(2);

    // normal cycle
    send(12'd1500, 16'h0830, 4'd1);
    chk("norm_activarB", activarB, 1);
    chk("norm_regando", regando, 1);
    chk("norm_estado", estado, 1);
    send(12'd1864, 16'h0830, 4'd1);
    chk("norm_stop_estado", estado, 2);
    chk("norm_stop_activarB", activarB, 0);
    chk("norm_stop_fallo", fallo, 0);
    cycles(100);
    send(12'd100, 16'h0830, 4'd1);
    chk("espera_ignora_listo", estado, 2);
    cycles(190);
    chk("espera_aun", estado, 2);
    cycles(12);
    chk("espera_fin", estado, 0);

    // threshold / hysteresis boundaries
    send(12'd1800, 16'h0830, 4'd1);
    chk("umbral_1800", estado, 0);
    send(12'd1799, 16'h0830, 4'd1);
    chk("umbral_1799", estado, 1);
    send(12'd1863, 16'h0830, 4'd1);
    chk("hist_1863", estado, 1);
    send(12'd1864, 16'h0830, 4'd1);
    chk("hist_1864", estado, 2);
    cycles(310);
    chk("hist_reposo", estado, 0);

    // other plant types
    send(12'd2399, 16'h0830, 4'd2);
    chk("tipo2_2399", estado, 1);
    send(12'd2463, 16'h0830, 4'd2);
    chk("tipo2_2463", estado, 1);
    send(12'd2464, 16'h0830, 4'd2);
    chk("tipo2_2464", estado, 2);
    cycles(310);
    send(12'd2000, 16'h0830, 4'd9);
    chk("tipo9_2000", estado, 0);
    send(12'd1200, 16'h0830, 4'd0);
    chk("tipo0_1200", estado, 0);

    // midday lockout
    send(12'd100, 16'h1200, 4'd1);
    chk("mediodia_1200", estado, 0);
    send(12'd100, 16'h1000, 4'd1);
    chk("mediodia_1000", estado, 0);
    send(12'd100, 16'h1600, 4'd1);
    chk("tarde_1600", estado, 1);
    send(12'd100, 16'h1200, 4'd1);
    chk("hora_corta_estado", estado, 2);
    chk("hora_corta_fallo", fallo, 0);
    cycles(310);

    // three consecutive run-time timeouts latch the fault
    for (int k = 1; k <= 3; k++) begin
      send(12'd500, 16'h0830, 4'd1);
      chk("to_inicio", estado, 1);
      for (int j = 0; j < 4; j++) begin
        cycles(19);
        send(12'd500, 16'h0830, 4'd1);
      end
      cycles(15);
      chk("to_antes", estado, 1);
      cycles(10);
      chk("to_estado", estado, (k < 3) ? 2 : 3);
      chk("to_fallo", fallo, 1);
      chk("to_activarB", activarB, 0);
      if (k < 3) begin
        cycles(310);
        chk("to_reposo", estado, 0);
      end
    end
    chk("falla_bloqueo", bloqueo, 1);
    send(12'd500, 16'h0830, 4'd1);
    chk("falla_absorbe", estado, 3);
    chk("falla_bomba", activarB, 0);
    cycles(400);
    chk("falla_sigue", estado, 3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("falla_rst_estado", estado, 0);
    chk("falla_rst_bloqueo", bloqueo, 0);
    chk("falla_rst_fallo", fallo, 0);
    @(negedge clk); rst_n = 1'b1;
    cycles(2);

    // frame loss, then a normal stop clears fallo
    send(12'd500, 16'h0830, 4'd1);
    cycles(25);
    chk("trama_antes", estado, 1);
    cycles(8);
    chk("trama_estado", estado, 2);
    chk("trama_fallo", fallo, 1);
    cycles(310);
    send(12'd500, 16'h0830, 4'd1);
    chk("trama_regando", estado, 1);
    chk("trama_fallo_reg", fallo, 1);
    send(12'd3000, 16'h0830, 4'd1);
    chk("trama_normal_estado", estado, 2);
    chk("trama_normal_fallo", fallo, 0);
    cycles(310);

    // module pull
    send(12'd500, 16'h0830, 4'd1);
    cycles(3);
    @(negedge clk); MODbomba = 1'b0;
    @(negedge clk);
    chk("mod_activarB", activarB, 0);
    chk("mod_estado", estado, 0);
    chk("mod_fallo", fallo, 0);
    send(12'd500, 16'h0830, 4'd1);
    chk("mod_sin_bomba", estado, 0);
    MODbomba = 1'b1;

    // asynchronous reset mid-watering
    send(12'd500, 16'h0830, 4'd1);
    cycles(2);
    chk("async_pre", activarB, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("async_activarB", activarB, 0);
    chk("async_estado", estado, 0);
    @(negedge clk); rst_n = 1'b1;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
